alu_result_psr: RTL
===================

// Module: alu_result_psr
// PURPOSE
//  Execute/writeback stage directly downstream of the combinational ALU. Captures the
//  ALU sum S and flag vector CLFZN into a 2-entry result queue feeding register-file
//  writeback, and holds the processor status register (PSR) flags. The PSR carry bit is
//  fed back to the ALU as carry-in for ADDC/ADDCI/ADDCU/ADDCUI.
// PARAMETERS
//  DATA_W     16  ALU result width
//  FLAG_W     5   flag vector width, bit order {C,L,F,Z,N} = [4:0]
//  RADDR_W    4   destination register index width
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        ALU result and control valid this cycle
//  in_ready     out  1        stage can accept (queue not full)
//  alu_s        in   DATA_W   ALU result S
//  alu_flags    in   FLAG_W   ALU CLFZN
//  flag_we      in   FLAG_W   per-flag PSR update mask for this op
//  wb_en        in   1        op writes alu_s to register file
//  wb_dest      in   RADDR_W  destination register index
//  flush        in   1        sync: discard queued results and the incoming op
//  psr_load     in   1        sync: software write of the whole PSR
//  psr_wdata    in   FLAG_W   value for psr_load
//  out_valid    out  1        queue head valid
//  out_ready    in   1        writeback consumes head this cycle
//  out_data     out  DATA_W   head result
//  out_wb_en    out  1        head write enable
//  out_dest     out  RADDR_W  head destination index
//  psr_flags    out  FLAG_W   current PSR {C,L,F,Z,N}
//  carry_out    out  1        psr_flags[4], ALU carry-in
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, both entries cleared, out_valid=0, out_data=0,
//    out_wb_en=0, out_dest=0, psr_flags=0, carry_out=0. Effective next edge after release.
//  - Queue: 2-entry circular FIFO, rd/wr pointers 1 bit each, count 0..2.
//    in_ready = (count != 2), combinational from count only (no pass-through when full).
//    out_valid = (count != 0); out_* driven from the entry at rd pointer.
//  - accept = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
//  - accept writes {alu_s,wb_en,wb_dest} at wr pointer; wr pointer toggles; pop toggles rd.
//    Count: +1 on accept only, -1 on pop only, unchanged on both. Pointers wrap 1->0.
//  - Latency: an accepted op appears on out_* the next cycle when queue was empty.
//  - Simultaneous accept+pop with count=1: head advances to new entry, count stays 1.
//  - Ops with wb_en=0 (e.g. CMP) are still queued to preserve order; consumer drops them.
//  - PSR update on accept: for each i, psr[i] <= flag_we[i] ? alu_flags[i] : psr[i].
//    New carry visible on carry_out the cycle after accept (one-cycle feedback).
//  - psr_load same cycle as accept: psr_load wins for all bits; alu flags discarded.
//  - flush: count<=0, pointers<=0, out_valid=0 next cycle; incoming op dropped and
//    PSR NOT updated by it; psr_load in the flush cycle still applies. PSR otherwise kept.
//  - in_valid while in_ready=0: no state change; upstream must hold inputs.
//  - No arithmetic performed on alu_s; width passes through unchanged.
// TESTING
//  1 Reset: assert rst_n=0 mid-run with count=2 -> out_valid=0, psr_flags=0, in_ready=1
//    immediately (async), no edge needed.
//  2 Single op: alu_s=16'h1234, wb_dest=3, wb_en=1, flag_we=5'b10010, alu_flags=5'b10010,
//    out_ready=1 -> next cycle out_data=16'h1234, out_dest=3, psr_flags=5'b10010, carry_out=1.
//  3 Backpressure: out_ready=0, push 16'h0001,16'h0002 -> in_ready=0 after 2nd; 3rd in_valid
//    ignored; release out_ready -> pops 16'h0001 then 16'h0002 in order, count 0.
//  4 Carry chain: op A flags C=1 accepted cycle n -> carry_out=1 at n+1; op B with
//    flag_we=5'b00010 leaves C=1, updates Z only.
//  5 Priority: psr_load=1, psr_wdata=5'b01000 with accept of alu_flags=5'b11111,
//    flag_we=5'b11111 -> psr_flags=5'b01000; result still queued.
//  6 Flush with count=2 plus in_valid -> count=0, out_valid=0 next cycle, PSR unchanged.

Source files
------------

// File: rtl/alu_result_psr.sv
// ---------------------------------------------------------------------------
// alu_result_psr
//
// Execute/writeback stage that sits directly after the combinational ALU.
// Each accepted op has its result {alu_s, wb_en, wb_dest} placed in a 2-entry
// FIFO that feeds register-file writeback. The same op can update the
// processor status register (PSR) flags {C,L,F,Z,N}. The PSR carry bit is
// returned to the ALU as its carry-in for the add-with-carry family.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    upstream handshake; in_ready = queue not full
//   alu_s, alu_flags       ALU sum and CLFZN flag vector
//   flag_we                per-flag PSR update mask for the incoming op
//   wb_en, wb_dest         writeback enable and destination register index
//   flush                  drop all queued results and the incoming op
//   psr_load, psr_wdata    software write of the whole PSR (beats ALU flags)
//   out_valid / out_ready  downstream handshake for the queue head
//   out_data, out_wb_en,
//   out_dest               queue head contents
//   psr_flags, carry_out   current PSR and its carry bit
// ---------------------------------------------------------------------------
module alu_result_psr #(
    parameter int DATA_W  = 16,
    parameter int FLAG_W  = 5,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_s,
    input  logic [FLAG_W-1:0]  alu_flags,
    input  logic [FLAG_W-1:0]  flag_we,
    input  logic               wb_en,
    input  logic [RADDR_W-1:0] wb_dest,
    input  logic               flush,
    input  logic               psr_load,
    input  logic [FLAG_W-1:0]  psr_wdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_wb_en,
    output logic [RADDR_W-1:0] out_dest,
    output logic [FLAG_W-1:0]  psr_flags,
    output logic               carry_out
);

    // Queue storage: two entries addressed by 1-bit circular pointers.
    logic [DATA_W-1:0]  data_r  [2];
    logic               wb_en_r [2];
    logic [RADDR_W-1:0] dest_r  [2];
    logic               rd_ptr_r;
    logic               wr_ptr_r;
    logic [1:0]         count_r;
    logic [FLAG_W-1:0]  psr_r;

    logic               accept_s;
    logic               pop_s;
    logic [FLAG_W-1:0]  psr_next_s;

    // Fullness is derived from count alone, so a full queue never takes a
    // new op in the same cycle the head drains.
    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);

    // The head fields come straight from storage registers.
    assign out_data  = data_r[rd_ptr_r];
    assign out_wb_en = wb_en_r[rd_ptr_r];
    assign out_dest  = dest_r[rd_ptr_r];

    assign psr_flags = psr_r;
    assign carry_out = psr_r[FLAG_W-1];

    // Handshake qualification; flush suppresses both directions.
    always_comb begin
        accept_s = 1'b0;
        pop_s    = 1'b0;
        if (flush) begin
            accept_s = 1'b0;
            pop_s    = 1'b0;
        end else begin
            accept_s = in_valid & in_ready;
            pop_s    = out_valid & out_ready;
        end
    end

    // Next PSR: software load wins outright, otherwise an accepted op
    // replaces only the flags it enables.
    always_comb begin
        psr_next_s = psr_r;
        if (psr_load) begin
            psr_next_s = psr_wdata;
        end else if (accept_s) begin
            psr_next_s = (psr_r & ~flag_we) | (alu_flags & flag_we);
        end else begin
            psr_next_s = psr_r;
        end
    end

    // Result queue: entry writes, pointer movement and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r[0]  <= {DATA_W{1'b0}};
            data_r[1]  <= {DATA_W{1'b0}};
            wb_en_r[0] <= 1'b0;
            wb_en_r[1] <= 1'b0;
            dest_r[0]  <= {RADDR_W{1'b0}};
            dest_r[1]  <= {RADDR_W{1'b0}};
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
        end else if (flush) begin
            // Entries keep stale contents; only occupancy and pointers clear.
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (accept_s) begin
                data_r[wr_ptr_r]  <= alu_s;
                wb_en_r[wr_ptr_r] <= wb_en;
                dest_r[wr_ptr_r]  <= wb_dest;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // PSR register; its carry bit feeds back to the ALU one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_r <= {FLAG_W{1'b0}};
        end else begin
            psr_r <= psr_next_s;
        end
    end

endmodule
